// File: rtl/hist_bank_ctrl.sv
// Ping-pong histogram bank controller: the magnitude stage fills the back bank,
// video reads the front bank, and the banks swap on vsync once a full frame is in.
module hist_bank_ctrl #(
    parameter int AW = 10,
    parameter int DW = 10,
    parameter int CW = 8
) (
    input  logic          clock_27mhz,
    input  logic          reset,
    input  logic          hwe,
    input  logic [AW-1:0] haddr,
    input  logic [DW-1:0] hdata,
    input  logic          vsync,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          bank_sel,
    output logic          frame_ready,
    output logic [DW-1:0] peak_mag,
    output logic [AW-1:0] peak_addr,
    output logic [CW-1:0] drop_count
);

    localparam int NBINS = 1 << AW;
    localparam logic [AW:0] CNT_LAST = (AW+1)'(NBINS - 1);

    typedef enum logic {
        FILL      = 1'b0,
        WAIT_SWAP = 1'b1
    } state_t;

    state_t        state_q;
    logic          bank_sel_q;
    logic          frame_ready_q;
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] peak_mag_q;
    logic [AW-1:0] peak_addr_q;
    logic [CW-1:0] drop_count_q;
    logic [AW:0]   wcnt_q;
    logic [AW:0]   dcnt_q;
    logic [DW-1:0] run_max_q;
    logic [AW-1:0] run_addr_q;

    logic [DW-1:0] bank0_mem [0:NBINS-1];
    logic [DW-1:0] bank1_mem [0:NBINS-1];

    logic wr_en;
    logic wr_to_bank1;

    // A write coincident with the swap lands in the old front, which becomes the new back.
    always_comb begin
        wr_en       = hwe && !reset && ((state_q == FILL) || vsync);
        wr_to_bank1 = (state_q == FILL) ? !bank_sel_q : bank_sel_q;
    end

    always_ff @(posedge clock_27mhz) begin
        if (wr_en && !wr_to_bank1) begin
            bank0_mem[haddr] <= hdata;
        end
        if (wr_en && wr_to_bank1) begin
            bank1_mem[haddr] <= hdata;
        end
    end

    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= bank_sel_q ? bank1_mem[rd_addr] : bank0_mem[rd_addr];
        end
    end

    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            state_q       <= FILL;
            bank_sel_q    <= 1'b0;
            frame_ready_q <= 1'b0;
            peak_mag_q    <= '0;
            peak_addr_q   <= '0;
            drop_count_q  <= '0;
            wcnt_q        <= '0;
            dcnt_q        <= '0;
            run_max_q     <= '0;
            run_addr_q    <= '0;
        end else begin
            frame_ready_q <= 1'b0;
            unique case (state_q)
                FILL: begin
                    if (hwe) begin
                        if (hdata > run_max_q) begin
                            run_max_q  <= hdata;
                            run_addr_q <= haddr;
                        end
                        if (wcnt_q == CNT_LAST) begin
                            wcnt_q  <= '0;
                            state_q <= WAIT_SWAP;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                end
                WAIT_SWAP: begin
                    if (vsync) begin
                        bank_sel_q    <= !bank_sel_q;
                        frame_ready_q <= 1'b1;
                        peak_mag_q    <= run_max_q;
                        peak_addr_q   <= run_addr_q;
                        dcnt_q        <= '0;
                        state_q       <= FILL;
                        if (hwe) begin
                            run_max_q  <= hdata;
                            run_addr_q <= haddr;
                            wcnt_q     <= (AW+1)'(1);
                        end else begin
                            run_max_q  <= '0;
                            run_addr_q <= '0;
                            wcnt_q     <= '0;
                        end
                    end else if (hwe) begin
                        if (dcnt_q == CNT_LAST) begin
                            dcnt_q <= '0;
                            if (drop_count_q != '1) begin
                                drop_count_q <= drop_count_q + 1'b1;
                            end
                        end else begin
                            dcnt_q <= dcnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign rd_data     = rd_data_q;
    assign bank_sel    = bank_sel_q;
    assign frame_ready = frame_ready_q;
    assign peak_mag    = peak_mag_q;
    assign peak_addr   = peak_addr_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_hist_bank_ctrl.sv
// Bench for hist_bank_ctrl: directed scenarios plus random traffic, all cycles
// checked against a frame-level model of the two banks.
module tb_hist_bank_ctrl;

    localparam int AW = 10;
    localparam int DW = 10;
    localparam int CW = 8;
    localparam int NB = 1 << AW;

    logic          clock_27mhz = 1'b0;
    logic          reset = 1'b1;
    logic          hwe = 1'b0;
    logic [AW-1:0] haddr = '0;
    logic [DW-1:0] hdata = '0;
    logic          vsync = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          bank_sel;
    logic          frame_ready;
    logic [DW-1:0] peak_mag;
    logic [AW-1:0] peak_addr;
    logic [CW-1:0] drop_count;

    hist_bank_ctrl #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clock_27mhz (clock_27mhz),
        .reset       (reset),
        .hwe         (hwe),
        .haddr       (haddr),
        .hdata       (hdata),
        .vsync       (vsync),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .bank_sel    (bank_sel),
        .frame_ready (frame_ready),
        .peak_mag    (peak_mag),
        .peak_addr   (peak_addr),
        .drop_count  (drop_count)
    );

    always #5 clock_27mhz = ~clock_27mhz;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Frame-level model: bank contents, the pending frame's write list, and
    // how many writes were thrown away while the finished frame waited.
    int mmem [2][NB];
    bit mval [2][NB];
    int m_front, m_full, m_wc, m_disc, m_drop, m_pmag, m_paddr, m_fr;
    int qa[$];
    int qd[$];

    task automatic model_reset();
        m_front = 0; m_full = 0; m_wc = 0; m_disc = 0; m_drop = 0;
        m_pmag = 0; m_paddr = 0; m_fr = 0;
        qa.delete(); qd.delete();
    endtask

    task automatic model_put(input int b, input int a, input int d);
        mmem[b][a] = d;
        mval[b][a] = 1'b1;
        qa.push_back(a);
        qd.push_back(d);
    endtask

    task automatic cycle(input bit w, input int a, input int d, input bit v, input int ra);
        int  exp_rd;
        bit  rd_ok;
        @(negedge clock_27mhz);
        reset = 1'b0; hwe = w; haddr = AW'(a); hdata = DW'(d); vsync = v; rd_addr = AW'(ra);
        rd_ok  = mval[m_front][ra];
        exp_rd = mmem[m_front][ra];
        m_fr = 0;
        if (!m_full) begin
            if (w) begin
                model_put(1 - m_front, a, d);
                m_wc++;
                if (m_wc == NB) begin
                    m_wc = 0; m_full = 1; m_disc = 0;
                end
            end
        end else if (v) begin
            m_front = 1 - m_front;
            m_fr = 1;
            m_pmag = 0; m_paddr = 0;
            foreach (qd[i]) if (qd[i] > m_pmag) begin m_pmag = qd[i]; m_paddr = qa[i]; end
            qa.delete(); qd.delete();
            m_full = 0; m_wc = 0;
            if (w) begin
                model_put(1 - m_front, a, d);
                m_wc = 1;
            end
        end else if (w) begin
            m_disc++;
            if ((m_disc % NB) == 0 && m_drop < (1 << CW) - 1) m_drop++;
        end
        @(posedge clock_27mhz);
        #1;
        check("frame_ready", frame_ready, m_fr);
        check("bank_sel", bank_sel, m_front);
        check("drop_count", drop_count, m_drop);
        check("peak_mag", peak_mag, m_pmag);
        check("peak_addr", peak_addr, m_paddr);
        if (rd_ok) check("rd_data", rd_data, exp_rd);
    endtask

    // Writes and vsync are driven during reset to show reset wins.
    task automatic apply_reset(input int n);
        @(negedge clock_27mhz);
        reset = 1'b1; hwe = 1'b1; vsync = 1'b1;
        haddr = AW'($urandom_range(0, NB - 1)); hdata = DW'($urandom_range(1, NB - 1));
        model_reset();
        repeat (n) @(posedge clock_27mhz);
        #1;
        check("rst_bank_sel", bank_sel, 0);
        check("rst_frame_ready", frame_ready, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_peak_mag", peak_mag, 0);
        check("rst_peak_addr", peak_addr, 0);
        check("rst_drop_count", drop_count, 0);
    endtask

    task automatic fill(input int n, input int start, input int d);
        for (int i = 0; i < n; i++) cycle(1'b1, (start + i) % NB, d, 1'b0, $urandom_range(0, NB - 1));
    endtask

    initial begin
        model_reset();
        apply_reset(3);

        // Full frame with hdata = haddr, then swap
        for (int i = 0; i < NB; i++) cycle(1'b1, i, i, 1'b0, 0);
        cycle(1'b0, 0, 0, 1'b1, 0);
        check("t1_frame_ready", frame_ready, 1);
        check("t1_bank_sel", bank_sel, 1);
        check("t1_peak_mag", peak_mag, 1023);
        check("t1_peak_addr", peak_addr, 1023);
        cycle(1'b0, 0, 0, 1'b0, 5);
        check("t1_frame_ready_drop", frame_ready, 0);
        check("t1_rd5", rd_data, 5);

        // Early vsync is ignored
        apply_reset(1);
        fill(512, 0, 17);
        cycle(1'b0, 0, 0, 1'b1, 0);
        check("t2_early_fr", frame_ready, 0);
        check("t2_early_bank", bank_sel, 0);
        fill(512, 512, 18);
        cycle(1'b0, 0, 0, 1'b1, 0);
        check("t2_swap_fr", frame_ready, 1);
        check("t2_swap_bank", bank_sel, 1);

        // Overrun: two full frames' worth of writes discarded
        apply_reset(1);
        fill(NB, 0, 1);
        fill(2 * NB, 0, 7);
        check("t3_drop_pre", drop_count, 2);
        cycle(1'b0, 0, 0, 1'b1, 0);
        check("t3_drop", drop_count, 2);
        for (int i = 0; i < NB; i++) begin
            cycle(1'b0, 0, 0, 1'b0, i);
            check("t3_front", rd_data, 1);
        end

        // Write coincident with vsync seeds the next frame
        apply_reset(1);
        for (int i = 0; i < NB; i++) cycle(1'b1, i, $urandom_range(0, 8), 1'b0, 0);
        cycle(1'b1, 3, 9, 1'b1, 0);
        check("t4_swap_bank", bank_sel, 1);
        for (int i = 0; i < NB; i++) if (i != 3) cycle(1'b1, i, $urandom_range(0, 8), 1'b0, 0);
        cycle(1'b0, 0, 0, 1'b1, 3);
        check("t4_fr", frame_ready, 1);
        check("t4_peak_mag", peak_mag, 9);
        check("t4_peak_addr", peak_addr, 3);
        cycle(1'b0, 0, 0, 1'b0, 3);
        check("t4_rd3", rd_data, 9);

        // Peak tie keeps the first address
        apply_reset(1);
        for (int i = 0; i < NB; i++) cycle(1'b1, i, (i == 7 || i == 9) ? 500 : 0, 1'b0, 0);
        cycle(1'b0, 0, 0, 1'b1, 0);
        check("t5_peak_mag", peak_mag, 500);
        check("t5_peak_addr", peak_addr, 7);

        // Reset mid-fill abandons the partial frame
        apply_reset(1);
        fill(300, 0, 44);
        apply_reset(1);
        fill(NB, 100, 45);
        cycle(1'b0, 0, 0, 1'b1, 0);
        check("t6_fr", frame_ready, 1);
        check("t6_bank", bank_sel, 1);
        check("t6_drop", drop_count, 0);
        check("t6_peak_addr", peak_addr, 100);

        // Random traffic
        for (int i = 0; i < 15000; i++) begin
            cycle(($urandom % 4) != 0, $urandom_range(0, NB - 1), $urandom_range(0, NB - 1),
                  ($urandom % 300) == 0, $urandom_range(0, NB - 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
